coefficient_loader: RTL and testbench

//  Upstream sequencer for the FIR filter core. When the bus register file flags a new

---
 rtl/coefficient_loader.sv | 152 +++++++++++++++
 tb/tb_coefficient_loader.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coefficient_loader.sv
// coefficient_loader: walks a coefficient bank into fir_filter with the modwait handshake.
// Optional per-wait timeout with load_err is built when COEFF_LOADER_TIMEOUT_EN is defined.
module coefficient_loader #(
   parameter  int NUM_COEFFS     = 4,
   parameter  int COEFF_W        = 16,
   parameter  int TIMEOUT_CYCLES = 256,
   localparam int IW             = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          new_coefficient_set,
   input  logic [NUM_COEFFS*COEFF_W-1:0] coeff_bank,
   input  logic                          modwait,
   output logic                          load_coeff,
   output logic [COEFF_W-1:0]            fir_coefficient,
   output logic [IW-1:0]                 coeff_idx,
   output logic                          clear_new_coeff,
   output logic                          busy,
   output logic                          load_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_NEXT,
      S_DONE
   } state_t;

   state_t               state_q;
   logic [IW-1:0]        idx_q;
   logic [IW-1:0]        idx_d;
   logic [COEFF_W-1:0]   coeff_q;
   logic                 load_q;
   logic                 clear_q;
   logic                 busy_q;
   logic                 err_q;
   logic                 wait_to;
   logic                 last_idx;

   assign idx_d    = idx_q + IW'(1);
   assign last_idx = (idx_q == IW'(NUM_COEFFS - 1));

`ifdef COEFF_LOADER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q;
   logic          in_wait;
   logic          wait_entry;

   assign in_wait    = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);
   assign wait_entry = (state_q == S_LOAD) ||
                       ((state_q == S_WAIT_ACK) && modwait);
   // Decision one cycle early so load_err lands TIMEOUT_CYCLES after LOAD
   assign wait_to    = in_wait && (cnt_q == CW'(TIMEOUT_CYCLES - 2));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else if (wait_entry) begin
         cnt_q <= '0;
      end else if (in_wait && !wait_to) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end
`else
   logic unused_timeout;

   assign wait_to        = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         coeff_q <= '0;
         load_q  <= 1'b0;
         clear_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         load_q  <= 1'b0;
         clear_q <= 1'b0;
         err_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               idx_q <= '0;
               if (new_coefficient_set && !modwait) begin
                  state_q <= S_LOAD;
                  load_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  coeff_q <= coeff_bank[0 +: COEFF_W];
               end
            end
            S_LOAD: begin
               state_q <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (modwait) begin
                  state_q <= S_WAIT_DONE;
               end else if (wait_to) begin
                  state_q <= S_IDLE;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end
            end
            S_WAIT_DONE: begin
               if (!modwait) begin
                  state_q <= S_NEXT;
               end else if (wait_to) begin
                  state_q <= S_IDLE;
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
               end
            end
            S_NEXT: begin
               if (last_idx) begin
                  state_q <= S_DONE;
                  clear_q <= 1'b1;
               end else begin
                  state_q <= S_LOAD;
                  idx_q   <= idx_d;
                  load_q  <= 1'b1;
                  coeff_q <= coeff_bank[idx_d*COEFF_W +: COEFF_W];
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               idx_q   <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               idx_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign load_coeff      = load_q;
   assign fir_coefficient = coeff_q;
   assign coeff_idx       = idx_q;
   assign clear_new_coeff = clear_q;
   assign busy            = busy_q;
   assign load_err        = err_q;

endmodule

// File: tb/tb_coefficient_loader.sv
// tb_coefficient_loader: directed tests for coefficient_loader with a small fir_filter modwait model.
// The timeout scenario is compiled only with COEFF_LOADER_TIMEOUT_EN.
module tb_coefficient_loader;

   localparam int N = 4;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           n_rst = 1'b0;
   logic           nsc = 1'b0;
   logic [N*W-1:0] bank;
   logic           modwait;
   logic           load_coeff;
   logic [W-1:0]   fir;
   logic [1:0]     cidx;
   logic           clear_new_coeff;
   logic           busy;
   logic           load_err;

   int checks = 0;
   int errors = 0;

   localparam logic [N*W-1:0] BANK0 = {16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
   logic [W-1:0] exp0 [N] = '{16'hFFFF, 16'hC000, 16'h8000, 16'h4000};

   coefficient_loader #(
      .NUM_COEFFS(N),
      .COEFF_W(W),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .new_coefficient_set(nsc),
      .coeff_bank(bank),
      .modwait(modwait),
      .load_coeff(load_coeff),
      .fir_coefficient(fir),
      .coeff_idx(cidx),
      .clear_new_coeff(clear_new_coeff),
      .busy(busy),
      .load_err(load_err)
   );

   always #5 clk = ~clk;

   // filter model: modwait rises the cycle after load_coeff, for hold cycles
   bit model_en = 1'b1;
   bit force_mw = 1'b0;
   int hold = 1;
   int mw_cnt = 0;
   always @(posedge clk) begin
      if (model_en && load_coeff) mw_cnt <= hold;
      else if (mw_cnt > 0) mw_cnt <= mw_cnt - 1;
   end
   assign modwait = force_mw | (mw_cnt != 0);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [W-1:0] p_val [$];
   int           p_idx [$];
   int           p_cyc [$];
   int           clr_cnt, busy_cnt, err_cnt, err_cyc, fir_chg;
   logic [W-1:0] held;

   always @(negedge clk) begin
      if (load_coeff) begin
         p_val.push_back(fir);
         p_idx.push_back(int'(cidx));
         p_cyc.push_back(cyc);
         held = fir;
      end else if (busy && fir !== held) begin
         fir_chg++;
      end
      if (clear_new_coeff) clr_cnt++;
      if (busy) busy_cnt++;
      if (load_err) begin
         if (err_cnt == 0) err_cyc = cyc;
         err_cnt++;
      end
   end

   task automatic clear_mon();
      p_val.delete();
      p_idx.delete();
      p_cyc.delete();
      clr_cnt  = 0;
      busy_cnt = 0;
      err_cnt  = 0;
      err_cyc  = 0;
      fir_chg  = 0;
      held     = fir;
   endtask

   // register-file model: drops the flag when clear_new_coeff is seen
   task automatic wait_idle(input int max, output bit ok);
      bit seen = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         #1;
         if (clear_new_coeff) nsc = 1'b0;
         if (busy) seen = 1'b1;
         else if (seen) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_pulses(input int n, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         #1;
         if (p_val.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      bit ok;
      n_rst = 1'b0;
      nsc   = 1'b1;
      bank  = BANK0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({load_coeff, clear_new_coeff, busy, load_err, fir, cidx} !== '0)
         $display("FAIL reset_outputs: got %0h expected 0",
                  {load_coeff, clear_new_coeff, busy, load_err, fir, cidx});
      if ({load_coeff, clear_new_coeff, busy, load_err, fir, cidx} !== '0) errors++;
      clear_mon();
      n_rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (load_coeff !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_load: got %b expected 1", load_coeff);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_busy: got %b expected 1", busy);
      end
      checks++;
      if (fir !== 16'hFFFF) begin
         errors++;
         $display("FAIL reset_first_coeff: got %h expected ffff", fir);
      end
      checks++;
      if (cidx !== 2'd0) begin
         errors++;
         $display("FAIL reset_first_idx: got %0d expected 0", cidx);
      end
      wait_idle(80, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_seq_timeout: got busy-stuck expected idle");
      end
   endtask

   task automatic test_sequence();
      bit ok;
      @(negedge clk);
      clear_mon();
      nsc = 1'b1;
      wait_idle(80, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL seq_timeout: got busy-stuck expected idle");
      end
      checks++;
      if (p_val.size() != 4) begin
         errors++;
         $display("FAIL seq_pulses: got %0d expected 4", p_val.size());
      end
      for (int i = 0; i < p_val.size() && i < 4; i++) begin
         checks++;
         if (p_val[i] !== exp0[i]) begin
            errors++;
            $display("FAIL seq_value[%0d]: got %h expected %h", i, p_val[i], exp0[i]);
         end
         checks++;
         if (p_idx[i] != i) begin
            errors++;
            $display("FAIL seq_idx[%0d]: got %0d expected %0d", i, p_idx[i], i);
         end
      end
      checks++;
      if (clr_cnt != 1) begin
         errors++;
         $display("FAIL seq_clear: got %0d expected 1", clr_cnt);
      end
      checks++;
      if (busy_cnt != 17) begin
         errors++;
         $display("FAIL seq_busy_cycles: got %0d expected 17", busy_cnt);
      end
      if (p_cyc.size() == 4) begin
         checks++;
         if (p_cyc[3] - p_cyc[0] != 12) begin
            errors++;
            $display("FAIL seq_span: got %0d expected 12", p_cyc[3] - p_cyc[0]);
         end
      end
      checks++;
      if (cidx !== 2'd0) begin
         errors++;
         $display("FAIL seq_idx_wrap: got %0d expected 0", cidx);
      end
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (p_val.size() != 4) begin
         errors++;
         $display("FAIL seq_no_retrigger: got %0d expected 4", p_val.size());
      end
   endtask

   task automatic test_modwait_defer();
      bit ok;
      int rel;
      @(negedge clk);
      clear_mon();
      force_mw = 1'b1;
      nsc = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (p_val.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL defer_hold: got pulses=%0d busy=%b expected 0 0", p_val.size(), busy);
      end
      force_mw = 1'b0;
      rel = cyc;
      wait_idle(80, ok);
      checks++;
      if (!ok || p_val.size() != 4) begin
         errors++;
         $display("FAIL defer_seq: got ok=%0d pulses=%0d expected 1 4", ok, p_val.size());
      end
      if (p_cyc.size() > 0) begin
         checks++;
         if (p_cyc[0] != rel + 1) begin
            errors++;
            $display("FAIL defer_latency: got %0d expected %0d", p_cyc[0] - rel, 1);
         end
      end
   endtask

   task automatic test_long_modwait();
      bit ok;
      @(negedge clk);
      clear_mon();
      hold = 10;
      nsc = 1'b1;
      wait_pulses(1, 20, ok);
      bank[0 +: W]   = 16'h1234;
      bank[3*W +: W] = 16'h0BAD;
      wait_idle(200, ok);
      checks++;
      if (!ok || p_val.size() != 4) begin
         errors++;
         $display("FAIL long_seq: got ok=%0d pulses=%0d expected 1 4", ok, p_val.size());
      end
      checks++;
      if (fir_chg != 0) begin
         errors++;
         $display("FAIL long_stable: got %0d changes expected 0", fir_chg);
      end
      checks++;
      if (busy_cnt != 53) begin
         errors++;
         $display("FAIL long_busy_cycles: got %0d expected 53", busy_cnt);
      end
      for (int i = 0; i + 1 < p_cyc.size(); i++) begin
         checks++;
         if (p_cyc[i+1] - p_cyc[i] != 13) begin
            errors++;
            $display("FAIL long_gap[%0d]: got %0d expected 13", i, p_cyc[i+1] - p_cyc[i]);
         end
      end
      if (p_val.size() == 4) begin
         checks++;
         if (p_val[0] !== 16'hFFFF || p_val[3] !== 16'h0BAD) begin
            errors++;
            $display("FAIL long_bank_sample: got %h/%h expected ffff/0bad", p_val[0], p_val[3]);
         end
      end
      hold = 1;
      bank = BANK0;
   endtask

   task automatic test_deassert();
      bit ok;
      @(negedge clk);
      clear_mon();
      nsc = 1'b1;
      wait_pulses(1, 20, ok);
      nsc = 1'b0;
      wait_idle(80, ok);
      checks++;
      if (!ok || p_val.size() != 4) begin
         errors++;
         $display("FAIL deassert_seq: got ok=%0d pulses=%0d expected 1 4", ok, p_val.size());
      end
      checks++;
      if (clr_cnt != 1) begin
         errors++;
         $display("FAIL deassert_clear: got %0d expected 1", clr_cnt);
      end
   endtask

   task automatic test_reset_abort();
      bit ok;
      @(negedge clk);
      clear_mon();
      nsc = 1'b1;
      wait_pulses(3, 40, ok);
      checks++;
      if (!ok || cidx !== 2'd2) begin
         errors++;
         $display("FAIL abort_reach_idx2: got ok=%0d idx=%0d expected 1 2", ok, cidx);
      end
      #2;
      n_rst = 1'b0;
      #1;
      checks++;
      if ({load_coeff, clear_new_coeff, busy, load_err, fir, cidx} !== '0) begin
         errors++;
         $display("FAIL abort_outputs: got %0h expected 0",
                  {load_coeff, clear_new_coeff, busy, load_err, fir, cidx});
      end
      @(negedge clk);
      n_rst = 1'b1;
      clear_mon();
      wait_pulses(1, 20, ok);
      checks++;
      if (!ok || p_idx[0] != 0 || p_val[0] !== 16'hFFFF) begin
         errors++;
         $display("FAIL abort_restart: got ok=%0d expected restart at idx 0 value ffff", ok);
      end
      wait_idle(80, ok);
      checks++;
      if (!ok || clr_cnt != 1 || p_val.size() != 4) begin
         errors++;
         $display("FAIL abort_complete: got clr=%0d pulses=%0d expected 1 4", clr_cnt, p_val.size());
      end
   endtask

`ifdef COEFF_LOADER_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      @(negedge clk);
      clear_mon();
      model_en = 1'b0;
      nsc = 1'b1;
      wait_pulses(2, 40, ok);
      model_en = 1'b1;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL to_retry_seen: got %0d pulses expected 2", p_val.size());
      end
      if (ok) begin
         checks++;
         if (err_cnt != 1 || err_cyc != p_cyc[0] + 8) begin
            errors++;
            $display("FAIL to_err_time: got cnt=%0d dt=%0d expected 1 8", err_cnt, err_cyc - p_cyc[0]);
         end
         checks++;
         if (p_cyc[1] != p_cyc[0] + 9 || p_idx[1] != 0) begin
            errors++;
            $display("FAIL to_retry: got dt=%0d idx=%0d expected 9 0", p_cyc[1] - p_cyc[0], p_idx[1]);
         end
         checks++;
         if (clr_cnt != 0) begin
            errors++;
            $display("FAIL to_no_clear: got %0d expected 0", clr_cnt);
         end
      end
      wait_idle(100, ok);
      checks++;
      if (!ok || clr_cnt != 1) begin
         errors++;
         $display("FAIL to_recover: got ok=%0d clr=%0d expected 1 1", ok, clr_cnt);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bank = BANK0;
      test_reset();
      test_sequence();
      test_modwait_defer();
      test_long_modwait();
      test_deassert();
      test_reset_abort();
`ifdef COEFF_LOADER_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
